// File: rtl/irq_ctrl.sv
// irq_ctrl: external interrupt controller feeding the core's 6-bit interrupt input.
// Synchronises up to NUM_SRC external lines and applies per-source polarity,
// edge/level mode, mask and routing onto one of 6 core lines.
// Core line 5 also merges the CP0 timer interrupt.
// Optional feature macro: IRQ_CTRL_CLAIM_EN (adds the CLAIM priority encoder at 0x18).
module irq_ctrl #(
   parameter int unsigned NUM_SRC     = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h1FD0_0000
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [NUM_SRC-1:0] i_irq,
   input  logic               i_timer_int,
   input  logic [31:0]        i_addr,
   input  logic [31:0]        i_wdata,
   input  logic               i_we,
   input  logic [3:0]         i_sel,
   output logic               o_hit,
   output logic [31:0]        o_rdata,
   output logic [5:0]         o_int
);

   localparam int unsigned RW        = 3 * NUM_SRC;
   localparam int unsigned NUM_LINES = 6;

   localparam logic [2:0] OFF_PEND  = 3'd0;
   localparam logic [2:0] OFF_MASK  = 3'd1;
   localparam logic [2:0] OFF_EDGE  = 3'd2;
   localparam logic [2:0] OFF_POL   = 3'd3;
   localparam logic [2:0] OFF_CLR   = 3'd4;
   localparam logic [2:0] OFF_ROUTE = 3'd5;
   localparam logic [2:0] OFF_CLAIM = 3'd6;

   // State
   logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
   logic [NUM_SRC-1:0] prev_q,  prev_d;
   logic [NUM_SRC-1:0] pend_q,  pend_d;
   logic [NUM_SRC-1:0] mask_q,  mask_d;
   logic [NUM_SRC-1:0] edge_q,  edge_d;
   logic [NUM_SRC-1:0] pol_q,   pol_d;
   logic [RW-1:0]      route_q, route_d;
   logic [5:0]         int_q,   int_d;

   // Combinational helpers
   logic               hit_c;
   logic               wr_c;
   logic [2:0]         off_c;
   logic [31:0]        be_c;
   logic [NUM_SRC-1:0] s_c;
   logic [NUM_SRC-1:0] a_c;
   logic [NUM_SRC-1:0] clr_c;
   logic [NUM_SRC-1:0] chg_c;
   logic [31:0]        claim_c;
   logic [31:0]        rdata_c;
   logic               unused_c;

   // Address decode and byte-lane expansion
   assign hit_c = (i_addr[31:5] == BASE_ADDR[31:5]);
   assign wr_c  = i_we & hit_c;
   assign off_c = i_addr[4:2];
   assign be_c  = {{8{i_sel[3]}}, {8{i_sel[2]}}, {8{i_sel[1]}}, {8{i_sel[0]}}};

   // Byte offset bits and write-data bits above the register widths are don't-care
   assign unused_c = ^{i_addr[1:0], i_wdata, be_c};

   // Synchronised source and polarity-adjusted activity
   assign s_c = sync_q[SYNC_STAGES-1];
   assign a_c = s_c ^ pol_q;

   // Input synchroniser chain
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int st = 0; st < int'(SYNC_STAGES); st++) begin
            sync_q[st] <= '0;
         end
      end else begin
         sync_q[0] <= i_irq;
         for (int st = 1; st < int'(SYNC_STAGES); st++) begin
            sync_q[st] <= sync_q[st-1];
         end
      end
   end

   // Next-state for config registers, pending bits, edge history and core lines
   always_comb begin
      mask_d  = mask_q;
      edge_d  = edge_q;
      pol_d   = pol_q;
      route_d = route_q;
      clr_c   = '0;

      if (wr_c) begin
         case (off_c)
            OFF_MASK:  mask_d  = (mask_q  & ~be_c[NUM_SRC-1:0]) | (i_wdata[NUM_SRC-1:0] & be_c[NUM_SRC-1:0]);
            OFF_EDGE:  edge_d  = (edge_q  & ~be_c[NUM_SRC-1:0]) | (i_wdata[NUM_SRC-1:0] & be_c[NUM_SRC-1:0]);
            OFF_POL:   pol_d   = (pol_q   & ~be_c[NUM_SRC-1:0]) | (i_wdata[NUM_SRC-1:0] & be_c[NUM_SRC-1:0]);
            OFF_CLR:   clr_c   = i_wdata[NUM_SRC-1:0] & be_c[NUM_SRC-1:0];
            OFF_ROUTE: route_d = (route_q & ~be_c[RW-1:0]) | (i_wdata[RW-1:0] & be_c[RW-1:0]);
            default:   ;
         endcase
      end

      // A mode/polarity change drops the pending bit and re-seeds the edge history
      // with the new activity level so the change itself never looks like an edge.
      chg_c  = (edge_d ^ edge_q) | (pol_d ^ pol_q);
      prev_d = (chg_c & (s_c ^ pol_d)) | (~chg_c & a_c);
      // Edge mode: a new edge wins over a same-cycle clear. Level mode: follow activity.
      pend_d = ~chg_c & ((edge_q & ((a_c & ~prev_q) | (pend_q & ~clr_c)))
                       | (~edge_q & a_c));

      // Route enabled pending sources onto the core lines
      int_d = '0;
      for (int k = 0; k < int'(NUM_LINES); k++) begin
         for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (pend_q[i] && mask_q[i] && (route_q[3*i +: 3] == 3'(k))) begin
               int_d[k] = 1'b1;
            end
         end
      end
      int_d[5] = int_d[5] | i_timer_int;
   end

   // Register state; reset overrides any same-cycle write
   always_ff @(posedge clk) begin
      if (!resetn) begin
         prev_q  <= '0;
         pend_q  <= '0;
         mask_q  <= '0;
         edge_q  <= '0;
         pol_q   <= '0;
         route_q <= '1;
         int_q   <= '0;
      end else begin
         prev_q  <= prev_d;
         pend_q  <= pend_d;
         mask_q  <= mask_d;
         edge_q  <= edge_d;
         pol_q   <= pol_d;
         route_q <= route_d;
         int_q   <= int_d;
      end
   end

`ifdef IRQ_CTRL_CLAIM_EN
   // Lowest-numbered enabled, routed, pending source; all ones when none
   always_comb begin
      claim_c = '1;
      for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
         if (pend_q[i] && mask_q[i] && (route_q[3*i +: 3] < 3'd6)) begin
            claim_c = 32'(i);
         end
      end
   end
`else
   assign claim_c = '0;
`endif

   // Combinational read mux
   always_comb begin
      rdata_c = '0;
      if (hit_c) begin
         case (off_c)
            OFF_PEND:  rdata_c = 32'(pend_q);
            OFF_MASK:  rdata_c = 32'(mask_q);
            OFF_EDGE:  rdata_c = 32'(edge_q);
            OFF_POL:   rdata_c = 32'(pol_q);
            OFF_ROUTE: rdata_c = 32'(route_q);
            OFF_CLAIM: rdata_c = claim_c;
            default:   rdata_c = '0;
         endcase
      end
   end

   assign o_hit   = hit_c;
   assign o_rdata = rdata_c;
   assign o_int   = int_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed testbench for irq_ctrl: register table plus multi-cycle sequences.
module tb_irq_ctrl;

   localparam logic [31:0] BASE = 32'h1FD0_0000;
`ifdef IRQ_CTRL_CLAIM_EN
   localparam bit CLAIM_ON = 1'b1;
`else
   localparam bit CLAIM_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        resetn;
   logic [7:0]  i_irq;
   logic        i_timer_int;
   logic [31:0] i_addr;
   logic [31:0] i_wdata;
   logic        i_we;
   logic [3:0]  i_sel;
   logic        o_hit;
   logic [31:0] o_rdata;
   logic [5:0]  o_int;

   int n_chk  = 0;
   int n_fail = 0;

   irq_ctrl dut (
      .clk         (clk),
      .resetn      (resetn),
      .i_irq       (i_irq),
      .i_timer_int (i_timer_int),
      .i_addr      (i_addr),
      .i_wdata     (i_wdata),
      .i_we        (i_we),
      .i_sel       (i_sel),
      .o_hit       (o_hit),
      .o_rdata     (o_rdata),
      .o_int       (o_int)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [4:0]  off;
      logic [31:0] wdata;
      logic [3:0]  sel;
      logic [31:0] exp;
   } vec_t;

   localparam int NV = 23;
   vec_t vecs [NV];

   function automatic logic [31:0] cexp(input logic [31:0] v);
      return CLAIM_ON ? v : 32'h0;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Advance n clock edges, land just after the last one
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One-cycle bus write, active on the next rising edge
   task automatic bus_wr(input logic [4:0] off, input logic [31:0] d, input logic [3:0] s);
      i_addr  = BASE + 32'(off);
      i_wdata = d;
      i_sel   = s;
      i_we    = 1'b1;
      @(posedge clk);
      #1;
      i_we    = 1'b0;
      i_sel   = 4'h0;
   endtask

   task automatic rd_chk(input string nm, input logic [4:0] off, input logic [31:0] exp);
      i_addr = BASE + 32'(off);
      #1;
      chk(nm, o_rdata, exp);
   endtask

   initial begin
      vecs[0]  = '{1'b0, 5'h00, 32'h0,         4'h0, 32'h0000_0000};
      vecs[1]  = '{1'b0, 5'h04, 32'h0,         4'h0, 32'h0000_0000};
      vecs[2]  = '{1'b0, 5'h08, 32'h0,         4'h0, 32'h0000_0000};
      vecs[3]  = '{1'b0, 5'h0C, 32'h0,         4'h0, 32'h0000_0000};
      vecs[4]  = '{1'b0, 5'h10, 32'h0,         4'h0, 32'h0000_0000};
      vecs[5]  = '{1'b0, 5'h14, 32'h0,         4'h0, 32'h00FF_FFFF};
      vecs[6]  = '{1'b0, 5'h18, 32'h0,         4'h0, cexp(32'hFFFF_FFFF)};
      vecs[7]  = '{1'b0, 5'h1C, 32'h0,         4'h0, 32'h0000_0000};
      vecs[8]  = '{1'b1, 5'h04, 32'hFFFF_FFFF, 4'h1, 32'h0000_00FF};
      vecs[9]  = '{1'b1, 5'h04, 32'h0000_0000, 4'hF, 32'h0000_0000};
      vecs[10] = '{1'b1, 5'h14, 32'h1234_5678, 4'hF, 32'h0034_5678};
      vecs[11] = '{1'b1, 5'h14, 32'h0000_0000, 4'h2, 32'h0034_0078};
      vecs[12] = '{1'b1, 5'h17, 32'hFFFF_FFFF, 4'hF, 32'h00FF_FFFF};
      vecs[13] = '{1'b1, 5'h1C, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000};
      vecs[14] = '{1'b1, 5'h10, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000};
      vecs[15] = '{1'b1, 5'h08, 32'h0000_00A5, 4'hF, 32'h0000_00A5};
      vecs[16] = '{1'b1, 5'h08, 32'hFFFF_FF00, 4'h1, 32'h0000_0000};
      vecs[17] = '{1'b1, 5'h0C, 32'h0000_005A, 4'hF, 32'h0000_005A};
      vecs[18] = '{1'b1, 5'h0C, 32'h0000_0000, 4'hF, 32'h0000_0000};
      vecs[19] = '{1'b0, 5'h00, 32'h0,         4'h0, 32'h0000_0000};
      vecs[20] = '{1'b1, 5'h04, 32'hFFFF_FFFF, 4'h0, 32'h0000_0000};
      vecs[21] = '{1'b1, 5'h04, 32'h0000_FF00, 4'hE, 32'h0000_0000};
      vecs[22] = '{1'b1, 5'h04, 32'h1234_5681, 4'h1, 32'h0000_0081};

      resetn      = 1'b0;
      i_irq       = 8'h00;
      i_timer_int = 1'b0;
      i_addr      = BASE;
      i_wdata     = 32'h0;
      i_we        = 1'b0;
      i_sel       = 4'h0;
      tick(3);
      resetn = 1'b1;
      tick(1);

      // Reset state and address decode
      chk("reset_o_int", 32'(o_int), 32'h0);
      i_addr = BASE + 32'h20; #1;
      chk("hit_above", 32'(o_hit), 32'h0);
      chk("rdata_miss", o_rdata, 32'h0);
      i_addr = BASE - 32'h4; #1;
      chk("hit_below", 32'(o_hit), 32'h0);
      i_addr = BASE + 32'h1C; #1;
      chk("hit_top", 32'(o_hit), 32'h1);

      // Register table
      for (int v = 0; v < NV; v++) begin
         if (vecs[v].wr) bus_wr(vecs[v].off, vecs[v].wdata, vecs[v].sel);
         rd_chk($sformatf("vec%0d", v), vecs[v].off, vecs[v].exp);
      end

      // Level source 0 -> line 3, latency SYNC_STAGES+2 edges both ways
      bus_wr(5'h04, 32'h0000_0000, 4'hF);
      bus_wr(5'h14, 32'h00FF_FFFB, 4'hF);
      bus_wr(5'h04, 32'h0000_0001, 4'hF);
      i_irq[0] = 1'b1;
      tick(3);
      chk("lvl_rise_early", 32'(o_int), 32'h00);
      rd_chk("lvl_pend", 5'h00, 32'h01);
      tick(1);
      chk("lvl_rise", 32'(o_int), 32'h08);
      i_irq[0] = 1'b0;
      tick(3);
      chk("lvl_fall_early", 32'(o_int), 32'h08);
      tick(1);
      chk("lvl_fall", 32'(o_int), 32'h00);

      // Edge source 1, active-low, routed to line 0
      bus_wr(5'h04, 32'h0000_0000, 4'hF);
      bus_wr(5'h14, 32'h00FF_FFFF, 4'hF);
      bus_wr(5'h08, 32'h0000_0002, 4'hF);
      i_irq[1] = 1'b1;
      tick(4);
      bus_wr(5'h0C, 32'h0000_0002, 4'hF);
      rd_chk("pol_chg_clear", 5'h00, 32'h0);
      bus_wr(5'h14, 32'h00FF_FFC7, 4'hF);
      bus_wr(5'h04, 32'h0000_0002, 4'hF);
      tick(2);
      rd_chk("edge_idle_pend", 5'h00, 32'h0);
      chk("edge_idle_int", 32'(o_int), 32'h00);
      i_irq[1] = 1'b0;
      tick(1);
      i_irq[1] = 1'b1;
      tick(4);
      rd_chk("edge_pend", 5'h00, 32'h02);
      chk("edge_int", 32'(o_int), 32'h01);
      tick(5);
      chk("edge_held", 32'(o_int), 32'h01);
      bus_wr(5'h10, 32'h0000_0002, 4'hF);
      rd_chk("w1c_pend", 5'h00, 32'h0);
      tick(1);
      chk("w1c_int", 32'(o_int), 32'h00);
      // New edge lands in the same cycle as the clear: set wins
      i_irq[1] = 1'b0;
      tick(1);
      i_irq[1] = 1'b1;
      tick(1);
      bus_wr(5'h10, 32'h0000_0002, 4'hF);
      rd_chk("set_wins", 5'h00, 32'h02);
      bus_wr(5'h10, 32'h0000_0002, 4'hF);
      rd_chk("clr_again", 5'h00, 32'h0);

      // Restore source 1 to idle level/active-high
      bus_wr(5'h04, 32'h0000_0000, 4'hF);
      i_irq[1] = 1'b0;
      tick(4);
      bus_wr(5'h08, 32'h0000_0000, 4'hF);
      bus_wr(5'h0C, 32'h0000_0000, 4'hF);
      tick(2);
      rd_chk("restore_pend", 5'h00, 32'h0);

      // Unrouted source 2 never drives a line; timer merge on line 5
      bus_wr(5'h14, 32'h00FF_FFBF, 4'hF);
      bus_wr(5'h04, 32'h0000_0004, 4'hF);
      i_irq[2] = 1'b1;
      tick(6);
      rd_chk("unrouted_pend", 5'h00, 32'h04);
      chk("unrouted_int", 32'(o_int), 32'h00);
      i_timer_int = 1'b1;
      #1;
      chk("timer_before", 32'(o_int), 32'h00);
      tick(1);
      chk("timer_on", 32'(o_int), 32'h20);
      i_timer_int = 1'b0;
      tick(1);
      chk("timer_off", 32'(o_int), 32'h00);

      // ROUTE and MASK writes reach o_int one edge after the write edge
      bus_wr(5'h14, 32'h00FF_FEBF, 4'hF);
      chk("route_lat0", 32'(o_int), 32'h00);
      tick(1);
      chk("route_lat1", 32'(o_int), 32'h04);
      bus_wr(5'h04, 32'h0000_0000, 4'hF);
      chk("mask_lat0", 32'(o_int), 32'h04);
      tick(1);
      chk("mask_lat1", 32'(o_int), 32'h00);

      // CLAIM: sources 2 (line 2) and 5 (line 1)
      i_irq[5] = 1'b1;
      bus_wr(5'h14, 32'h00FC_FEBF, 4'hF);
      bus_wr(5'h04, 32'h0000_0024, 4'hF);
      tick(4);
      rd_chk("claim_pend", 5'h00, 32'h24);
      chk("claim_int", 32'(o_int), 32'h06);
      rd_chk("claim_2", 5'h18, cexp(32'd2));
      bus_wr(5'h04, 32'h0000_0020, 4'hF);
      rd_chk("claim_5", 5'h18, cexp(32'd5));
      bus_wr(5'h04, 32'h0000_0000, 4'hF);
      rd_chk("claim_none", 5'h18, cexp(32'hFFFF_FFFF));

      // Write coinciding with a reset edge is discarded
      i_irq = 8'h00;
      resetn = 1'b0;
      bus_wr(5'h04, 32'hFFFF_FFFF, 4'h1);
      resetn = 1'b1;
      rd_chk("rst_wins_mask", 5'h04, 32'h0);
      rd_chk("rst_route", 5'h14, 32'h00FF_FFFF);
      rd_chk("rst_pend", 5'h00, 32'h0);
      chk("rst_int", 32'(o_int), 32'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
Interrupt controller that sits directly upstream of the core's 6-bit hardware interrupt input and drives it. It synchronises up to 8 external IRQ lines and applies per-source polarity, edge/level mode, mask and routing to one of the 6 core lines. Core line 5 also carries the CP0 timer interrupt. Software configures it through memory-mapped registers on the core's data-memory bus, which uses combinational reads and clocked writes.

Parameters:
NUM_SRC, 8, number of external sources (1..8)
SYNC_STAGES, 2, flip-flop stages in each input synchroniser (>=2)
BASE_ADDR, 32'h1FD0_0000, region base; must be 32-byte aligned

Ports:
clk  in  1  clock
resetn  in  1  reset; synchronous, active-low
i_irq  in  NUM_SRC  asynchronous external interrupt requests
i_timer_int  in  1  timer interrupt from CP0 (already synchronous)
i_addr  in  32  data-bus byte address
i_wdata  in  32  data-bus write data
i_we  in  1  data-bus write strobe
i_sel  in  4  byte enables; bit n covers wdata[8n+7:8n]
o_hit  out  1  combinational; i_addr[31:5]==BASE_ADDR[31:5]
o_rdata  out  32  combinational read data; 0 when !o_hit
o_int  out  6  registered interrupt lines to the core

Behaviour:
- Register map (word offsets; i_addr[1:0] ignored; bits at or above NUM_SRC read 0, writes to them are ignored):
  - 0x00 PEND: RO pending bits.
  - 0x04 MASK: RW; 1 = enabled.
  - 0x08 EDGE: RW; 1 = edge-triggered, 0 = level.
  - 0x0C POL: RW; 0 = active-high / rising edge, 1 = active-low / falling edge.
  - 0x10 CLR: W1C on edge-mode pending bits; reads 0.
  - 0x14 ROUTE: RW; 3 bits per source at [3i+2:3i]. Values 0..5 select the core line; 6 and 7 mean unrouted.
  - 0x18: see Optional Feature.
  - 0x1C: reads 0, writes ignored.
- Writes: take effect on the clk edge where i_we & o_hit. Only byte lanes with i_sel set are updated.
- Reset (resetn==0 at clk edge):
  - synchronisers, edge-history flops, PEND, MASK, EDGE, POL = 0
  - ROUTE = all 3'b111
  - o_int = 6'b0
  - Reset overrides any same-cycle write.
- Synchroniser: i_irq[i] passes through SYNC_STAGES flops to give s[i]. a[i] = s[i] ^ POL[i]. prev[i] holds a[i] from the previous cycle.
- Level mode (EDGE[i]=0): PEND[i] <= a[i] every cycle. CLR has no effect.
- Edge mode (EDGE[i]=1):
  - PEND[i] sets on a[i] & ~prev[i] and stays set until cleared by CLR.
  - A set and a clear in the same cycle: set wins.
- Writing EDGE or POL clears PEND for every source whose EDGE or POL bit changed. prev[i] is reloaded with the new a[i], so no spurious edge results.
- Output, registered:
  - For line k in 0..5, o_int[k] <= OR over i of (PEND[i] & MASK[i] & ROUTE[i]==k).
  - o_int[5] additionally ORs in i_timer_int.
- Latency:
  - External edge or level to o_int: SYNC_STAGES+2 clk edges.
  - i_timer_int to o_int[5]: 1 edge.
  - MASK/ROUTE write to o_int change: 1 edge after the write edge.
- Glitches narrower than one clk period may be missed; this is acceptable. Stable pulses of one cycle or longer must be captured in edge mode.
- No internal state machine beyond the pending logic. The block must not stall; the bus is always ready.

Optional Feature:
IRQ_CTRL_CLAIM_EN
- Defined: offset 0x18 CLAIM is RO and has no read side effect.
  - It returns the index of the lowest-numbered i where PEND[i] & MASK[i] & ROUTE[i]<6.
  - It returns 32'hFFFF_FFFF when no such source exists.
  - The value is computed combinationally from the current registers.
- Undefined: 0x18 reads 0 and no priority encoder is built.

Test Plan:
- Reset, then read 0x00–0x1C at BASE_ADDR: all read 0 except ROUTE=0x00FF_FFFF; o_int=0; o_hit=0 at BASE_ADDR+0x20.
- Level source: MASK=0x01, ROUTE[2:0]=3, SYNC_STAGES=2. Raise i_irq[0] before edge 0 -> o_int=6'b001000 after edge 4. Drop i_irq[0] -> o_int clears 4 edges later.
- Edge source with W1C: EDGE=0x02, POL=0x02, MASK=0x02, ROUTE[5:3]=0. A 1-cycle low pulse on i_irq[1] -> PEND=0x02 and o_int[0]=1 held. Writing CLR=0x02 -> PEND=0, o_int[0]=0 next edge. Another falling edge arriving in the clear cycle -> PEND stays 0x02.
- Byte write: MASK=0, write 0xFFFF_FFFF to 0x04 with i_sel=4'b0001 -> MASK reads 0x0000_00FF. Same write during a resetn=0 edge -> MASK reads 0.
- Timer merge plus unrouted source: i_timer_int=1 -> o_int[5]=1 after 1 edge. A source with ROUTE=6, pending and masked on, never drives o_int.
- With IRQ_CTRL_CLAIM_EN: sources 2 and 5 pending and enabled -> CLAIM reads 2. Mask source 2 -> CLAIM reads 5. Nothing pending -> CLAIM reads 0xFFFF_FFFF. Without the macro, 0x18 reads 0.
